// File: rtl/neuron_multi_level_input_pkg.sv
// rtl/neuron_multi_level_input_pkg.sv - shared constants for the multi-level input driver
package neuron_multi_level_input_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE       = 4'd0;
  localparam state_t ST_LOAD       = 4'd1;
  localparam state_t ST_CHECK      = 4'd2;
  localparam state_t ST_MASK       = 4'd3;
  localparam state_t ST_SPI_TRIG   = 4'd4;
  localparam state_t ST_SPI_WAIT   = 4'd5;
  localparam state_t ST_PULSE_TRIG = 4'd6;
  localparam state_t ST_PULSE_WAIT = 4'd7;
  localparam state_t ST_NEXT       = 4'd8;
  localparam state_t ST_DONE       = 4'd9;

  localparam logic [1:0] CFG_NONE      = 2'b00;
  localparam logic [1:0] CFG_SPI_WRITE = 2'b10;

  // One row field per byte of the pipe word: sign on top, magnitude below
  localparam int FIELD_W         = 8;
  localparam int FIELDS_PER_WORD = 4;
  localparam int SIGN_BIT        = 7;
  localparam int MAG_LSB         = 0;

endpackage

// File: rtl/neuron_mask_gen.sv
// rtl/neuron_mask_gen.sv - row-enable mask: rows whose magnitude still exceeds the iteration
module neuron_mask_gen
  import neuron_multi_level_input_pkg::*;
#(
  parameter int SPI_LENGTH = 256,
  parameter int MAG_W      = 7
) (
  input  logic [SPI_LENGTH-1:0][MAG_W-1:0] mag,
  input  logic [MAG_W-1:0]                 iter_count,
  output logic [SPI_LENGTH-1:0]            mask
);

  always_comb begin
    mask = '0;
    for (int r = 0; r < SPI_LENGTH; r++) begin
      mask[r] = (mag[r] > iter_count);
    end
  end

endmodule

// File: rtl/neuron_multi_level_input.sv
// rtl/neuron_multi_level_input.sv - loads per-row pulse counts and replays them as SPI mask + pulse iterations
module neuron_multi_level_input
  import neuron_multi_level_input_pkg::*;
#(
  parameter int SPI_LENGTH  = 256,
  parameter int TRIG_CYCLES = 4,
  parameter int MAG_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_trigger,
  input  logic                  run_trigger,
  output logic                  idle,
  output logic                  run_done,
  input  logic [31:0]           pipe_in,
  input  logic                  pipe_in_valid,
  output logic                  pipe_in_ready,
  output logic [SPI_LENGTH-1:0] spi_output,
  output logic [SPI_LENGTH-1:0] input_sign,
  output logic                  spi_write_trigger,
  input  logic                  spi_done,
  output logic                  pulse_trigger,
  input  logic                  pulse_idle,
  output logic [1:0]            reg_config,
  output logic [MAG_W-1:0]      iter_count
);

  localparam int WORDS = SPI_LENGTH / FIELDS_PER_WORD;
  localparam int WCW   = $clog2(WORDS);
  localparam int HCW   = $clog2(TRIG_CYCLES + 1);

  state_t                          state, next_state;
  logic [SPI_LENGTH-1:0][MAG_W-1:0] mag;
  logic [SPI_LENGTH-1:0]           sign;
  logic [MAG_W-1:0]                max_mag, word_max;
  logic [WCW-1:0]                  word_cnt;
  logic [HCW-1:0]                  hold_cnt;
  logic [SPI_LENGTH-1:0]           mask;
  logic                            accept, hold_done;

  neuron_mask_gen #(.SPI_LENGTH(SPI_LENGTH), .MAG_W(MAG_W)) u_mask_gen (
    .mag        (mag),
    .iter_count (iter_count),
    .mask       (mask)
  );

  assign accept    = pipe_in_valid && pipe_in_ready;
  assign hold_done = (hold_cnt == HCW'(TRIG_CYCLES - 1));

  always_comb begin
    word_max = max_mag;
    for (int j = 0; j < FIELDS_PER_WORD; j++) begin
      if (pipe_in[FIELD_W*j + MAG_LSB +: MAG_W] > word_max)
        word_max = pipe_in[FIELD_W*j + MAG_LSB +: MAG_W];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:       if (load_trigger) next_state = ST_LOAD;
                     else if (run_trigger) next_state = ST_CHECK;
      ST_LOAD:       if (accept && word_cnt == WCW'(WORDS - 1)) next_state = ST_IDLE;
      ST_CHECK:      next_state = (max_mag == '0) ? ST_DONE : ST_MASK;
      ST_MASK:       next_state = ST_SPI_TRIG;
      ST_SPI_TRIG:   if (hold_done) next_state = ST_SPI_WAIT;
      ST_SPI_WAIT:   if (spi_done) next_state = ST_PULSE_TRIG;
      ST_PULSE_TRIG: if (hold_done) next_state = ST_PULSE_WAIT;
      ST_PULSE_WAIT: if (pulse_idle) next_state = ST_NEXT;
      ST_NEXT:       next_state = (iter_count + 1'b1 == max_mag) ? ST_DONE : ST_MASK;
      ST_DONE:       next_state = ST_IDLE;
      default:       next_state = ST_IDLE;
    endcase
  end

  // Strobes are registered from the state being entered so they line up with it;
  // idle deliberately trails the state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      idle              <= 1'b0;
      run_done          <= 1'b0;
      pipe_in_ready     <= 1'b0;
      spi_write_trigger <= 1'b0;
      pulse_trigger     <= 1'b0;
      reg_config        <= CFG_NONE;
      spi_output        <= '0;
      input_sign        <= '0;
      iter_count        <= '0;
      mag               <= '0;
      sign              <= '0;
      max_mag           <= '0;
      word_cnt          <= '0;
      hold_cnt          <= '0;
    end else begin
      state             <= next_state;
      idle              <= (state == ST_IDLE);
      run_done          <= (next_state == ST_DONE);
      pipe_in_ready     <= (next_state == ST_LOAD);
      spi_write_trigger <= (next_state == ST_SPI_TRIG);
      pulse_trigger     <= (next_state == ST_PULSE_TRIG);
      reg_config        <= (next_state == ST_SPI_TRIG || next_state == ST_SPI_WAIT)
                           ? CFG_SPI_WRITE : CFG_NONE;
      hold_cnt          <= ((state == ST_SPI_TRIG || state == ST_PULSE_TRIG) && next_state == state)
                           ? hold_cnt + 1'b1 : '0;

      if (state == ST_IDLE && next_state == ST_LOAD) begin
        word_cnt <= '0;
        max_mag  <= '0;
      end
      if (accept) begin
        for (int j = 0; j < FIELDS_PER_WORD; j++) begin
          mag[{word_cnt, 2'(j)}]  <= pipe_in[FIELD_W*j + MAG_LSB +: MAG_W];
          sign[{word_cnt, 2'(j)}] <= pipe_in[FIELD_W*j + SIGN_BIT];
        end
        word_cnt <= word_cnt + 1'b1;
        max_mag  <= word_max;
      end

      if (next_state == ST_CHECK) begin
        iter_count <= '0;
        input_sign <= sign;
      end
      if (state == ST_MASK) spi_output <= mask;
      if (state == ST_NEXT) iter_count <= iter_count + 1'b1;
      if (next_state == ST_DONE) spi_output <= '0;
    end
  end

endmodule

// File: tb/tb_neuron_multi_level_input.sv
// tb/tb_neuron_multi_level_input.sv - directed bench for the multi-level input driver
module tb_neuron_multi_level_input;

  localparam int N = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_trigger = 1'b0, run_trigger = 1'b0;
  logic          idle, run_done;
  logic [31:0]   pipe_in = '0;
  logic          pipe_in_valid = 1'b0, pipe_in_ready;
  logic [N-1:0]  spi_output, input_sign;
  logic          spi_write_trigger, pulse_trigger;
  logic          spi_done = 1'b1, pulse_idle = 1'b1;
  logic [1:0]    reg_config;
  logic [6:0]    iter_count;

  int vectors = 0, miscompares = 0;
  logic [7:0] ref_bytes [N];
  int row_pulses [N];
  logic [3:0] masks [128];
  int n_spi, n_pulse, n_spi_hi, n_pulse_hi, n_done, last_iter;
  bit done_seen, activity, slow = 0, hold_spi = 0;
  int periph_cnt = 0;

  neuron_multi_level_input dut (
    .clk(clk), .rst_n(rst_n), .load_trigger(load_trigger), .run_trigger(run_trigger),
    .idle(idle), .run_done(run_done), .pipe_in(pipe_in), .pipe_in_valid(pipe_in_valid),
    .pipe_in_ready(pipe_in_ready), .spi_output(spi_output), .input_sign(input_sign),
    .spi_write_trigger(spi_write_trigger), .spi_done(spi_done), .pulse_trigger(pulse_trigger),
    .pulse_idle(pulse_idle), .reg_config(reg_config), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // Peripheral model: instant completion, or a 3-cycle lag after each trigger when slow
  always @(negedge clk) begin
    if (spi_write_trigger || pulse_trigger) periph_cnt = 3;
    else if (periph_cnt > 0) periph_cnt--;
    spi_done   = !hold_spi && (!slow || periph_cnt == 0);
    pulse_idle = !slow || periph_cnt == 0;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_ref();
    for (int r = 0; r < N; r++) ref_bytes[r] = 8'h00;
  endtask

  task automatic feed_words(input bit gaps);
    int w = 0, guard = 0;
    activity = 0;
    while (w < N/4 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (spi_write_trigger || pulse_trigger) activity = 1;
      for (int j = 0; j < 4; j++) pipe_in[8*j +: 8] = ref_bytes[4*w + j];
      pipe_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pipe_in_valid && pipe_in_ready) w++;
    end
    @(negedge clk);
    pipe_in_valid = 1'b0;
    vectors++;
    if (w != N/4) begin
      miscompares++;
      $display("FAIL load_words: accepted %0d words, required %0d", w, N/4);
    end
    vectors++;
    if (pipe_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_after_load: got %b, required 0", pipe_in_ready);
    end
  endtask

  task automatic do_load(input bit gaps);
    @(negedge clk) load_trigger = 1'b1;
    @(negedge clk) load_trigger = 1'b0;
    feed_words(gaps);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_run(input bit poke);
    bit prev_spi = 0, prev_pulse = 0;
    n_spi = 0; n_pulse = 0; n_spi_hi = 0; n_pulse_hi = 0; n_done = 0; last_iter = -1; done_seen = 0;
    for (int r = 0; r < N; r++) row_pulses[r] = 0;
    @(negedge clk) run_trigger = 1'b1;
    @(negedge clk) run_trigger = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (poke && cyc == 10) begin load_trigger = 1'b1; run_trigger = 1'b1; end
      if (poke && cyc == 11) begin load_trigger = 1'b0; run_trigger = 1'b0; end
      if (spi_write_trigger) begin
        n_spi_hi++;
        if (!prev_spi) begin
          if (n_spi < 128) masks[n_spi] = spi_output[3:0];
          last_iter = int'(iter_count);
          n_spi++;
        end
      end
      if (pulse_trigger) begin
        n_pulse_hi++;
        if (!prev_pulse) begin
          n_pulse++;
          for (int r = 0; r < N; r++) if (spi_output[r]) row_pulses[r]++;
        end
      end
      prev_spi = spi_write_trigger;
      prev_pulse = pulse_trigger;
      if (run_done) begin n_done++; done_seen = 1; end
      else if (done_seen && idle) break;
      @(negedge clk);
    end
    load_trigger = 1'b0; run_trigger = 1'b0;
    vectors++;
    if (!(done_seen && idle)) begin
      miscompares++;
      $display("FAIL run_timeout: done_seen=%0d idle=%b, required 1/1", done_seen, idle);
    end
    vectors++;
    if (n_done != 1) begin
      miscompares++;
      $display("FAIL run_done_width: %0d cycles high, required 1", n_done);
    end
  endtask

  task automatic check_row_pulses(input string name);
    int bad = 0;
    for (int r = 0; r < N; r++) if (row_pulses[r] != int'(ref_bytes[r][6:0])) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s: %0d rows with wrong pulse count, required 0", name, bad);
    end
  endtask

  task automatic check_reset_values(input string name);
    vectors++;
    if ({idle, run_done, pipe_in_ready, spi_write_trigger, pulse_trigger} !== 5'b0) begin
      miscompares++;
      $display("FAIL %s_strobes: got %b, required 00000", name,
               {idle, run_done, pipe_in_ready, spi_write_trigger, pulse_trigger});
    end
    vectors++;
    if (reg_config !== 2'b00 || iter_count !== 7'd0) begin
      miscompares++;
      $display("FAIL %s_cfg_iter: got %b/%0d, required 00/0", name, reg_config, iter_count);
    end
    vectors++;
    if (spi_output !== '0 || input_sign !== '0) begin
      miscompares++;
      $display("FAIL %s_vectors: spi_output=%0h input_sign=%0h, required 0/0", name, spi_output, input_sign);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (idle !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b, required 1", idle);
    end
  endtask

  task automatic test_zero_load();
    clear_ref();
    do_load(0);
    do_run(0);
    vectors++;
    if (n_spi != 0 || n_pulse != 0) begin
      miscompares++;
      $display("FAIL zero_run_activity: spi=%0d pulse=%0d, required 0/0", n_spi, n_pulse);
    end
  endtask

  task automatic test_small_pattern();
    clear_ref();
    ref_bytes[0] = 8'h03; ref_bytes[1] = 8'h01; ref_bytes[2] = 8'h82; ref_bytes[3] = 8'h00;
    slow = 1;
    do_load(0);
    for (int rep = 0; rep < 2; rep++) begin
      do_run(0);
      vectors++;
      if (n_spi != 3 || n_pulse != 3) begin
        miscompares++;
        $display("FAIL small_counts: spi=%0d pulse=%0d, required 3/3", n_spi, n_pulse);
      end
      vectors++;
      if (masks[0] !== 4'b0111 || masks[1] !== 4'b0101 || masks[2] !== 4'b0001) begin
        miscompares++;
        $display("FAIL small_masks: got %b %b %b, required 0111 0101 0001", masks[0], masks[1], masks[2]);
      end
      vectors++;
      if (n_spi_hi != 12 || n_pulse_hi != 12) begin
        miscompares++;
        $display("FAIL trigger_hold: spi_hi=%0d pulse_hi=%0d, required 12/12", n_spi_hi, n_pulse_hi);
      end
      vectors++;
      if (input_sign !== 256'h4) begin
        miscompares++;
        $display("FAIL small_sign: got %0h, required 4", input_sign);
      end
      vectors++;
      if (spi_output !== '0) begin
        miscompares++;
        $display("FAIL spi_output_cleared: got %0h, required 0", spi_output);
      end
      check_row_pulses("small_rows");
    end
    slow = 0;
  endtask

  task automatic test_max_magnitude();
    clear_ref();
    ref_bytes[200] = 8'h7F;
    ref_bytes[5]   = 8'h85;
    do_load(0);
    do_run(0);
    vectors++;
    if (n_spi != 127 || n_pulse != 127) begin
      miscompares++;
      $display("FAIL max_counts: spi=%0d pulse=%0d, required 127/127", n_spi, n_pulse);
    end
    vectors++;
    if (last_iter != 126) begin
      miscompares++;
      $display("FAIL max_last_iter: got %0d, required 126", last_iter);
    end
    check_row_pulses("max_rows");
  endtask

  task automatic test_valid_gaps();
    logic [N-1:0] exp_sign;
    int exp_max = 0;
    for (int r = 0; r < N; r++) begin
      ref_bytes[r] = 8'($urandom_range(0, 255));
      exp_sign[r] = ref_bytes[r][7];
      if (int'(ref_bytes[r][6:0]) > exp_max) exp_max = int'(ref_bytes[r][6:0]);
    end
    do_load(1);
    do_run(0);
    vectors++;
    if (n_spi != exp_max || n_pulse != exp_max) begin
      miscompares++;
      $display("FAIL gaps_counts: spi=%0d pulse=%0d, required %0d", n_spi, n_pulse, exp_max);
    end
    vectors++;
    if (input_sign !== exp_sign) begin
      miscompares++;
      $display("FAIL gaps_sign: got %0h, required %0h", input_sign, exp_sign);
    end
    check_row_pulses("gaps_rows");
  endtask

  task automatic test_trigger_collision();
    clear_ref();
    for (int r = 0; r < 4; r++) ref_bytes[r] = 8'h02;
    @(negedge clk) begin load_trigger = 1'b1; run_trigger = 1'b1; end
    @(negedge clk) begin load_trigger = 1'b0; run_trigger = 1'b0; end
    vectors++;
    if (pipe_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_load: pipe_in_ready=%b, required 1", pipe_in_ready);
    end
    feed_words(0);
    vectors++;
    if (activity) begin
      miscompares++;
      $display("FAIL collision_activity: trigger seen during load, required none");
    end
    repeat (2) @(negedge clk);
    do_run(1);
    vectors++;
    if (n_spi != 2 || n_pulse != 2) begin
      miscompares++;
      $display("FAIL ignored_triggers: spi=%0d pulse=%0d, required 2/2", n_spi, n_pulse);
    end
    vectors++;
    if (pipe_in_ready !== 1'b0 || idle !== 1'b1) begin
      miscompares++;
      $display("FAIL after_poke_state: ready=%b idle=%b, required 0/1", pipe_in_ready, idle);
    end
    check_row_pulses("collision_rows");
  endtask

  task automatic test_reset_mid_run();
    bit reached = 0;
    clear_ref();
    ref_bytes[0] = 8'h90;
    do_load(0);
    hold_spi = 1;
    @(negedge clk) run_trigger = 1'b1;
    @(negedge clk) run_trigger = 1'b0;
    for (int cyc = 0; cyc < 50 && !reached; cyc++) begin
      @(negedge clk);
      if (reg_config == 2'b10 && !spi_write_trigger) reached = 1;
    end
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("FAIL reach_spi_wait: not reached within 50 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk) begin rst_n = 1'b1; hold_spi = 0; end
    repeat (2) @(negedge clk);
    do_run(0);
    vectors++;
    if (n_spi != 0 || n_pulse != 0) begin
      miscompares++;
      $display("FAIL run_after_reset: spi=%0d pulse=%0d, required 0/0", n_spi, n_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_zero_load();
    test_small_pattern();
    test_max_magnitude();
    test_valid_gaps();
    test_trigger_collision();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
